// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - calculator button types and helpers shared by the button front end
// Contents:
//   buttons_t       one bit per physical button, at most one bit set on calculator.buttons_i
//   button_t        encoded button code, B_NONE when nothing is pressed
//   NumButtons      number of bits in buttons_t
//   buttons2button  one-hot vector -> code (lowest set bit wins, B_NONE on zero)
//   button2buttons  code -> one-hot vector (all zero for B_NONE)
//   btn_fsm_e       press-issue controller states
package calc_pkg;

  typedef struct packed {
    logic clear;
    logic op_eq;
    logic op_div;
    logic op_mul;
    logic op_sub;
    logic op_add;
    logic num_9;
    logic num_8;
    logic num_7;
    logic num_6;
    logic num_5;
    logic num_4;
    logic num_3;
    logic num_2;
    logic num_1;
    logic num_0;
  } buttons_t;

  localparam int NumButtons = $bits(buttons_t);

  // Code n+1 corresponds to bit n of buttons_t, so code 0 is free for B_NONE.
  typedef enum logic [4:0] {
    B_NONE   = 5'd0,
    B_NUM_0  = 5'd1,
    B_NUM_1  = 5'd2,
    B_NUM_2  = 5'd3,
    B_NUM_3  = 5'd4,
    B_NUM_4  = 5'd5,
    B_NUM_5  = 5'd6,
    B_NUM_6  = 5'd7,
    B_NUM_7  = 5'd8,
    B_NUM_8  = 5'd9,
    B_NUM_9  = 5'd10,
    B_OP_ADD = 5'd11,
    B_OP_SUB = 5'd12,
    B_OP_MUL = 5'd13,
    B_OP_DIV = 5'd14,
    B_OP_EQ  = 5'd15,
    B_CLEAR  = 5'd16
  } button_t;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} btn_fsm_e;

  function automatic button_t buttons2button(buttons_t b);
    logic [NumButtons-1:0] v;
    button_t code;
    v = b;
    code = B_NONE;
    for (int i = NumButtons - 1; i >= 0; i--) begin
      if (v[i]) code = button_t'(5'(i + 1));
    end
    return code;
  endfunction

  function automatic buttons_t button2buttons(button_t c);
    logic [NumButtons-1:0] v;
    v = '0;
    for (int i = 0; i < NumButtons; i++) begin
      v[i] = (c == button_t'(5'(i + 1)));
    end
    return buttons_t'(v);
  endfunction

endpackage

// File: rtl/button_fifo.sv
// rtl/button_fifo.sv - synchronous FIFO of encoded button presses
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and code; taken when not full or when popping in the same cycle
//   pop_i           read request; advances the head when not empty
//   data_o          current head entry
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
module button_fifo
  import calc_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  button_t                  data_i,
  input  logic                     pop_i,
  output button_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  button_t        mem [Depth];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= B_NONE;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= data_i;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces raw buttons and issues one-hot press pulses to the calculator
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   raw_buttons_i   raw, bouncy, asynchronous button levels
//   busy_i          calculator controller is not idle
//   buttons_o       one-hot press pulse (one cycle) or all zero
//   overflow_o      one-cycle pulse when a press is dropped because the buffer is full
//   multi_press_o   one-cycle pulse when several buttons rise together (all dropped)
//   pending_o       presses buffered and not yet issued
module button_conditioner
  import calc_pkg::*;
#(
  parameter int DebounceCycles = 4,
  parameter int FifoDepth      = 4,
  parameter int SettleCycles   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  buttons_t                     raw_buttons_i,
  input  logic                         busy_i,
  output buttons_t                     buttons_o,
  output logic                         overflow_o,
  output logic                         multi_press_o,
  output logic [$clog2(FifoDepth):0]   pending_o
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
  localparam int SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [SetW-1:0] SetMax = SetW'(SettleCycles - 1);

  logic [NumButtons-1:0] sync1_q, sync2_q, deb_q, deb_d, rise;
  logic [CntW-1:0]       stable_cnt_q;
  logic [SetW-1:0]       settle_q;
  logic                  stable, push, multi, pop, fifo_full, fifo_empty;
  button_t               push_code, head;
  btn_fsm_e              state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_buttons_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    // sync1_q is next cycle's synchronized vector, so a mismatch means it is changing now.
    stable    = (sync1_q == sync2_q);
    deb_d     = (stable && stable_cnt_q == CntMax) ? sync2_q : deb_q;
    rise      = deb_d & ~deb_q;
    push      = ($countones(rise) == 1);
    multi     = ($countones(rise) > 1);
    push_code = buttons2button(buttons_t'(rise));
    pop       = (state_q == IDLE) && !fifo_empty && !busy_i;
  end

  // One counter shared by all bits: any change anywhere restarts the stability window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_cnt_q <= '0;
      deb_q        <= '0;
    end else begin
      if (!stable) stable_cnt_q <= '0;
      else if (stable_cnt_q != CntMax) stable_cnt_q <= stable_cnt_q + CntW'(1);
      deb_q <= deb_d;
    end
  end

  button_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_code),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_o)
  );

  // SETTLE ignores busy_i because the controller needs a cycle or more to leave idle
  // after seeing a press; WAIT then holds until it is back in idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      settle_q      <= '0;
      buttons_o     <= '0;
      overflow_o    <= 1'b0;
      multi_press_o <= 1'b0;
    end else begin
      buttons_o     <= '0;
      overflow_o    <= push && fifo_full && !pop;
      multi_press_o <= multi;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            buttons_o <= button2buttons(head);
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          settle_q <= '0;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == SetMax) state_q <= WAIT;
          else settle_q <= settle_q + SetW'(1);
        end
        WAIT: begin
          if (!busy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
  import calc_pkg::*;

  localparam int DEB = 4;
  localparam int SET = 1;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  buttons_t   raw;
  logic       busy;
  buttons_t   btn_o;
  logic       ovf_o, multi_o;
  logic [2:0] pend_o;

  always #5 clk_i = ~clk_i;

  button_conditioner #(
    .DebounceCycles (DEB),
    .FifoDepth      (4),
    .SettleCycles   (SET)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .raw_buttons_i (raw),
    .busy_i        (busy),
    .buttons_o     (btn_o),
    .overflow_o    (ovf_o),
    .multi_press_o (multi_o),
    .pending_o     (pend_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] key(input string nm);
    buttons_t b;
    b = '0;
    case (nm)
      "1": b.num_1 = 1'b1;
      "2": b.num_2 = 1'b1;
      "3": b.num_3 = 1'b1;
      "5": b.num_5 = 1'b1;
      "7": b.num_7 = 1'b1;
      "9": b.num_9 = 1'b1;
      "+": b.op_add = 1'b1;
      "-": b.op_sub = 1'b1;
      "=": b.op_eq = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

  task automatic press(input logic [15:0] v, input int hold, input int gap);
    raw = buttons_t'(v);
    tick(hold);
    raw = '0;
    tick(gap);
  endtask

  // Pulse log: the edge at which the calculator samples each pulse, and its value.
  int          pulse_edge[$];
  logic [15:0] pulse_val[$];
  int          ovf_cnt = 0;
  int          multi_cnt = 0;
  int          last_edge = -1;

  // Reference model: a button level counts as debounced once DEB+1 consecutive
  // clock samples of the raw level agree; a single new debounced press is queued,
  // several at once are flagged.
  logic        model_en = 1'b0;
  logic [15:0] hist[$];
  logic [15:0] mdl_d, mdl_nd, mdl_rise;
  logic        exp_multi = 1'b0;
  logic [15:0] exp_q[$];
  bit          settled;

  always @(posedge clk_i) begin
    if (!model_en) begin
      hist.delete();
      for (int i = 0; i <= DEB; i++) hist.push_back('0);
      mdl_d     = '0;
      exp_multi = 1'b0;
    end else begin
      settled = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) settled = 1'b0;
      mdl_nd    = settled ? hist[0] : mdl_d;
      mdl_rise  = mdl_nd & ~mdl_d;
      exp_multi = ($countones(mdl_rise) >= 2);
      if ($countones(mdl_rise) == 1) exp_q.push_back(mdl_rise);
      mdl_d = mdl_nd;
      hist.push_back(raw);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk_i) begin
    chk("onehot", 32'($countones(btn_o) <= 1), 1);
    if (ovf_o) ovf_cnt++;
    if (multi_o) multi_cnt++;
    if (btn_o != '0) begin
      if (last_edge >= 0) chk("pulse_gap", 32'((cyc + 1 - last_edge) >= 2 + SET), 1);
      last_edge = cyc + 1;
      pulse_edge.push_back(cyc + 1);
      pulse_val.push_back(btn_o);
      if (model_en) begin
        chk("issue_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("issue_order", btn_o, exp_q.pop_front());
      end
    end
    if (model_en) begin
      chk("multi_model", multi_o, exp_multi);
      chk("no_overflow", ovf_o, 0);
    end
  end

  int base, k0, o0, m0;
  logic [15:0] seq[4];
  logic [15:0] v;
  int idx, idx2;

  initial begin
    rst_ni = 1'b0;
    raw    = '0;
    busy   = 1'b0;
    tick(3);
    chk("rst_buttons", btn_o, 0);
    chk("rst_overflow", ovf_o, 0);
    chk("rst_multi", multi_o, 0);
    chk("rst_pending", pend_o, 0);
    rst_ni = 1'b1;
    tick(6);

    // Clean press of 5, held 10 cycles.
    base = pulse_val.size();
    k0   = cyc;
    press(key("5"), 10, 20);
    chk("t1_count", pulse_val.size() - base, 1);
    if (pulse_val.size() > base) begin
      chk("t1_value", pulse_val[base], key("5"));
      chk("t1_latency", pulse_edge[base] - k0, 2 + DEB + 2);
    end

    // Bouncing 3: toggles every 2 cycles for 12 cycles, then stays high.
    base = pulse_val.size();
    for (int i = 0; i < 6; i++) begin
      raw = (i % 2 == 0) ? buttons_t'(key("3")) : buttons_t'(16'h0);
      tick(2);
    end
    k0 = cyc;
    press(key("3"), 12, 20);
    chk("t2_count", pulse_val.size() - base, 1);
    if (pulse_val.size() > base) begin
      chk("t2_value", pulse_val[base], key("3"));
      chk("t2_latency", pulse_edge[base] - k0, DEB + 4);
    end

    // Busy controller: four presses buffer, a fifth overflows.
    busy   = 1'b1;
    base   = pulse_val.size();
    seq[0] = key("1");
    seq[1] = key("+");
    seq[2] = key("2");
    seq[3] = key("=");
    for (int i = 0; i < 4; i++) press(seq[i], 8, 8);
    chk("t3_pending_full", pend_o, 4);
    chk("t3_no_pulse_busy", pulse_val.size() - base, 0);
    o0 = ovf_cnt;
    press(key("7"), 8, 10);
    chk("t3_overflow", ovf_cnt - o0, 1);
    chk("t3_pending_kept", pend_o, 4);
    busy = 1'b0;
    tick(40);
    chk("t3_drain_count", pulse_val.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (pulse_val.size() > base + i) chk("t3_order", pulse_val[base + i], seq[i]);
    end
    for (int i = 1; i < 4; i++) begin
      if (pulse_val.size() > base + i)
        chk("t3_spacing", 32'((pulse_edge[base + i] - pulse_edge[base + i - 1]) >= 3), 1);
    end
    chk("t3_pending_empty", pend_o, 0);

    // Simultaneous + and - rise.
    base = pulse_val.size();
    m0   = multi_cnt;
    press(key("+") | key("-"), 8, 15);
    chk("t4_multi", multi_cnt - m0, 1);
    chk("t4_no_pulse", pulse_val.size() - base, 0);
    chk("t4_pending", pend_o, 0);

    // Reset while settling after the first of three buffered presses.
    busy = 1'b1;
    for (int i = 0; i < 3; i++) press((i == 0) ? key("1") : (i == 1) ? key("2") : key("3"), 8, 8);
    chk("t5_pending3", pend_o, 3);
    base = pulse_val.size();
    busy = 1'b0;
    tick(2);
    chk("t5_pending2", pend_o, 2);
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_buttons", btn_o, 0);
    chk("t5_rst_pending", pend_o, 0);
    tick(1);
    rst_ni = 1'b1;
    tick(30);
    chk("t5_only_first", pulse_val.size() - base, 1);
    if (pulse_val.size() > base) chk("t5_first_value", pulse_val[base], key("1"));
    press(key("9"), 8, 10);
    chk("t5_new_press", pulse_val.size() - base, 2);
    if (pulse_val.size() > base + 1) chk("t5_new_value", pulse_val[base + 1], key("9"));

    // Randomized presses, bounces and chords against the reference model.
    rst_ni = 1'b0;
    tick(2);
    exp_q.delete();
    rst_ni   = 1'b1;
    model_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      v   = 16'(1) << idx;
      if ($urandom_range(0, 4) == 0) begin
        idx2 = (idx + 1 + $urandom_range(0, 14)) % 16;
        v    = v | (16'(1) << idx2);
      end
      repeat ($urandom_range(0, 3)) begin
        raw = buttons_t'(v);
        tick($urandom_range(1, 3));
        raw = '0;
        tick($urandom_range(1, 3));
      end
      raw = buttons_t'(v);
      tick($urandom_range(6, 12));
      repeat ($urandom_range(0, 2)) begin
        raw = '0;
        tick(1);
        raw = buttons_t'(v);
        tick($urandom_range(1, 2));
      end
      raw = '0;
      tick($urandom_range(8, 14));
    end
    tick(30);
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_pending", pend_o, 0);
    model_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
